pipeline_ctrl: RTL
==================

// Module: pipeline_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage pipeline. Drives per-latch
//  enable/flush for IF/ID, ID/EX, EX/MEM and MEM/WB plus PC enable/select.
//  Resolves dcache freeze, branch/jump redirect (resolved in MEM), load-use bubble,
//  icache miss bubble and halt drain. Keeps saturating stall/flush perf counters.
// PARAMETERS
//  CNT_W         16  width of perf counters stall_cnt / flush_cnt
//  DRAIN_CYCLES  2   cycles after halt leaves MEM before halt_out (MEM/WB retire)
// PORTS
//  CLK          in   1      clock, rising edge
//  nRST         in   1      asynchronous, active-low reset
//  ihit         in   1      icache returns instr this cycle
//  dhit         in   1      dcache completes access this cycle
//  exmem_dREN   in   1      load in MEM (EX/MEM latch output)
//  exmem_dWEN   in   1      store in MEM
//  br_taken_mem in   1      beq/bne in MEM, condition true
//  jump_mem     in   1      j/jal in MEM
//  jr_mem       in   1      jr in MEM
//  halt_mem     in   1      halt in MEM
//  idex_dREN    in   1      load in EX (ID/EX latch output)
//  idex_wsel    in   5      dest reg of that load
//  ifid_rs      in   5      rs of instr in ID
//  ifid_rt      in   5      rt of instr in ID
//  pc_en        out  1      PC register load enable
//  pc_sel       out  2      0 pc+4, 1 branch target, 2 jump target, 3 rdat1 (jr)
//  ifid_en/ifid_flush, idex_en/idex_flush, exmem_en/exmem_flush,
//  memwb_en/memwb_flush   out 1 each  latch enable; flush loads bubble (only with en=1)
//  halt_out     out  1      sticky CPU halted
//  stall_cnt    out  CNT_W  cycles with any stall, saturating
//  flush_cnt    out  CNT_W  redirects taken, saturating
// BEHAVIOUR
//  - Reset (nRST=0): state=RUN, drain_cnt=0, halt_out=0, counters=0; all en/flush=0,
//    pc_en=0, pc_sel=0 (comb outputs gated by nRST). Exit: next edge is normal RUN.
//  - States: RUN, DRAIN, HALTED. Comb outputs, zero latency from inputs.
//  - RUN priority (highest first), default all en=1, flush=0, pc_en=1, pc_sel=0:
//    1 dmem wait: (exmem_dREN|exmem_dWEN)&!dhit -> all en=0, pc_en=0, no flush;
//      a redirect/halt in MEM is held, acted on in the dhit cycle.
//    2 redirect: br_taken_mem|jump_mem|jr_mem -> pc_sel 1/2/3 (br>jump>jr if
//      several), ifid/idex/exmem_flush=1, memwb normal; flush_cnt++. ihit ignored.
//    3 halt_mem -> ifid/idex/exmem_flush=1, pc_en=0; next state DRAIN, drain_cnt=0.
//    4 load-use: idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs|idex_wsel==ifid_rt)
//      -> pc_en=0, ifid_en=0, idex_flush=1; EX/MEM, MEM/WB advance.
//    5 !ihit -> pc_en=0, ifid_flush=1; downstream advance (4 and 5 together: 4 wins).
//  - stall_cnt++ on any cycle where case 1, 4 or 5 applies; saturate at all-ones.
//  - DRAIN: pc_en=0, ifid/idex/exmem_flush=1, memwb_en=1; drain_cnt++ per cycle;
//    drain_cnt==DRAIN_CYCLES-1 -> HALTED. Inputs ignored.
//  - HALTED: all en=0, pc_en=0, halt_out=1; remains until nRST.
//  - Reset mid-DRAIN or mid-freeze: immediate return to reset values.
// STRUCTURE
//  - cpu_types_pkg: add pcsel_t enum (PC_NEXT, PC_BR, PC_J, PC_JR),
//    pctl_state_t enum (RUN, DRAIN, HALTED); regbits_t reused for 5-bit regs.
//  - One sub-module: sat_counter (#W, inc, count) instantiated twice for perf counters.
//  - Next-state/output in one always_comb, state/drain_cnt/halt_out in always_ff.
// TESTING
//  - Load-use: idex_dREN=1,idex_wsel=5,ifid_rt=5,ihit=1 -> pc_en=0,ifid_en=0,
//    idex_flush=1, exmem_en=1; stall_cnt 0->1.
//  - Dcache miss: exmem_dREN=1,dhit=0 for 3 cycles with br_taken_mem=1 -> all en=0
//    3 cycles, flush_cnt stays 0; dhit=1 -> pc_sel=1, flushes, flush_cnt=1.
//  - Redirect + !ihit: jr_mem=1, ihit=0 -> pc_sel=3, ifid_flush=1, pc_en=1.
//  - Halt: halt_mem=1 in RUN -> DRAIN 2 cycles (memwb_en=1), then halt_out=1, all
//    en=0; later ihit/br_taken_mem toggles produce no change.
//  - Saturation: CNT_W=4, hold ihit=0 20 cycles -> stall_cnt stops at 15.
//  - Async reset asserted mid-DRAIN (between edges) -> outputs 0 immediately,
//    halt_out=0, counters=0; RUN resumes on first edge after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types (register index, PC select, controller state)
package cpu_types_pkg;
    typedef logic [4:0] regbits_t;
    typedef enum logic [1:0] {PC_NEXT, PC_BR, PC_J, PC_JR} pcsel_t;
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} pctl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones
//   CLK, nRST (async active-low) | inc: count this cycle | count: current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge CLK, negedge nRST)
        if (!nRST) count <= '0;
        else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/sequencing controller for the 5-stage pipeline
//   CLK, nRST (async active-low)
//   in : ihit, dhit, exmem_dREN/dWEN, br_taken_mem, jump_mem, jr_mem, halt_mem,
//        idex_dREN, idex_wsel, ifid_rs, ifid_rt
//   out: pc_en, pc_sel, per-latch en/flush, halt_out, stall_cnt, flush_cnt
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_dREN,
    input  logic             exmem_dWEN,
    input  logic             br_taken_mem,
    input  logic             jump_mem,
    input  logic             jr_mem,
    input  logic             halt_mem,
    input  logic             idex_dREN,
    input  regbits_t         idex_wsel,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt_out,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;

    pctl_state_t state, nstate;
    logic [DW-1:0] drain_cnt, ndrain_cnt;
    logic freeze, redirect, load_use, stall_inc, flush_inc;
    pcsel_t sel;

    assign freeze   = (exmem_dREN | exmem_dWEN) & !dhit;
    assign redirect = br_taken_mem | jump_mem | jr_mem;
    assign load_use = idex_dREN & (idex_wsel != '0) &
                      ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));
    assign pc_sel   = sel;

    // outputs are forced low while nRST is held, independent of state
    always_comb begin
        nstate      = state;
        ndrain_cnt  = drain_cnt;
        sel         = PC_NEXT;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (nRST) begin
            unique case (state)
                RUN: begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '1;
                    if (freeze) begin
                        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
                        stall_inc = 1'b1;
                    end else if (redirect) begin
                        sel = br_taken_mem ? PC_BR : jump_mem ? PC_J : PC_JR;
                        {ifid_flush, idex_flush, exmem_flush} = '1;
                        flush_inc = 1'b1;
                    end else if (halt_mem) begin
                        {ifid_flush, idex_flush, exmem_flush} = '1;
                        pc_en      = 1'b0;
                        nstate     = DRAIN;
                        ndrain_cnt = '0;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end else if (!ihit) begin
                        pc_en      = 1'b0;
                        ifid_flush = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
                DRAIN: begin
                    {ifid_en, idex_en, exmem_en, memwb_en} = '1;
                    {ifid_flush, idex_flush, exmem_flush} = '1;
                    ndrain_cnt = drain_cnt + 1'b1;
                    if (32'(drain_cnt) == DRAIN_CYCLES - 1) nstate = HALTED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK, negedge nRST)
        if (!nRST) begin
            state     <= RUN;
            drain_cnt <= '0;
            halt_out  <= 1'b0;
        end else begin
            state     <= nstate;
            drain_cnt <= ndrain_cnt;
            halt_out  <= nstate == HALTED;
        end

    sat_counter #(.W(CNT_W)) u_stall (.CLK(CLK), .nRST(nRST), .inc(stall_inc), .count(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush (.CLK(CLK), .nRST(nRST), .inc(flush_inc), .count(flush_cnt));
endmodule
